// File: rtl/mem_access_sequencer_pkg.sv
// Shared types, trap codes and op3 decode helpers for the memory access sequencer.
package mem_access_sequencer_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned TT_W   = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_MAR,
        S_RD_WAIT,
        S_MDR_LD,
        S_WR_WAIT,
        S_WB,
        S_NEXT,
        S_FIN,
        S_TRAP
    } state_t;

    localparam logic [TT_W-1:0] TT_NONE    = 3'd0;
    localparam logic [TT_W-1:0] TT_ILLEGAL = 3'd1;
    localparam logic [TT_W-1:0] TT_ALIGN   = 3'd2;
    localparam logic [TT_W-1:0] TT_DACC    = 3'd3;

    localparam logic [OP_W-1:0] OP_LD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_LDUB = 6'b000001;
    localparam logic [OP_W-1:0] OP_LDUH = 6'b000010;
    localparam logic [OP_W-1:0] OP_LDD  = 6'b000011;
    localparam logic [OP_W-1:0] OP_ST   = 6'b000100;
    localparam logic [OP_W-1:0] OP_STB  = 6'b000101;
    localparam logic [OP_W-1:0] OP_STH  = 6'b000110;
    localparam logic [OP_W-1:0] OP_STD  = 6'b000111;
    localparam logic [OP_W-1:0] OP_LDSB = 6'b001001;
    localparam logic [OP_W-1:0] OP_LDSH = 6'b001010;
    localparam logic [OP_W-1:0] OP_SWAP = 6'b001111;

    // Read-only ops, including the double-word load.
    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op inside {OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_LDD};
    endfunction

    // Write-only ops, including the double-word store.
    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op inside {OP_ST, OP_STB, OP_STH, OP_STD};
    endfunction

    function automatic logic is_double(input logic [OP_W-1:0] op);
        return op inside {OP_LDD, OP_STD};
    endfunction

    function automatic logic is_half(input logic [OP_W-1:0] op);
        return op inside {OP_LDUH, OP_LDSH, OP_STH};
    endfunction

    function automatic logic is_swap(input logic [OP_W-1:0] op);
        return op == OP_SWAP;
    endfunction

    function automatic logic is_word(input logic [OP_W-1:0] op);
        return op inside {OP_LD, OP_ST, OP_SWAP};
    endfunction

    // Unknown op3, or a double-word op naming an odd register pair.
    function automatic logic is_illegal(input logic [OP_W-1:0] op, input logic [RD_W-1:0] rd);
        return !(is_load(op) || is_store(op) || is_swap(op)) || (is_double(op) && rd[0]);
    endfunction

    // Second pass of a double-word op uses the datapath's +4 address and is not rechecked.
    function automatic logic is_misaligned(input logic [OP_W-1:0]   op,
                                           input logic [ADDR_W-1:0] addr_lo,
                                           input logic              second);
        return (is_word(op) && (addr_lo[1:0] != 2'b00))
            || (is_half(op) && addr_lo[0])
            || (is_double(op) && !second && (addr_lo != 3'b000));
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Control-unit / RAM side handshake and datapath strobes of the sequencer.
interface mem_access_sequencer_if;
    import mem_access_sequencer_pkg::*;

    logic              start;
    logic [OP_W-1:0]   op3;
    logic [RD_W-1:0]   rd;
    logic [ADDR_W-1:0] addr_lo;
    logic              MFC;

    logic              busy;
    logic              done;
    logic              trap;
    logic [TT_W-1:0]   tt;
    logic              MAR_Enable;
    logic              MDR_Enable;
    logic              RAM_enable;
    logic              TEMP_Enable;
    logic              register_file;
    logic              MDR_Mux_select;
    logic              wb_src;
    logic              word_sel;
    logic [OP_W-1:0]   RAM_OpCode;
    logic [RD_W-1:0]   in_PC;

    modport master (
        output start, op3, rd, addr_lo, MFC,
        input  busy, done, trap, tt, MAR_Enable, MDR_Enable, RAM_enable, TEMP_Enable,
               register_file, MDR_Mux_select, wb_src, word_sel, RAM_OpCode, in_PC
    );

    modport slave (
        input  start, op3, rd, addr_lo, MFC,
        output busy, done, trap, tt, MAR_Enable, MDR_Enable, RAM_enable, TEMP_Enable,
               register_file, MDR_Mux_select, wb_src, word_sel, RAM_OpCode, in_PC
    );

endinterface

// File: rtl/mem_access_sequencer_timeout.sv
// Wait-state cycle counter; expired flags the last cycle allowed before a timeout.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic Clk,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT - 1));

    // Count wait cycles, saturating at the expiry value.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one load/store/swap (single or double word) through MAR/MDR/RAM using MFC.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input logic                   Clk,
    input logic                   RESET,
    mem_access_sequencer_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [TT_W-1:0]   tt_nxt;
    logic [OP_W-1:0]   op_q;
    logic [RD_W-1:0]   rd_q;
    logic              ws_q;
    logic [TT_W-1:0]   tt_q;
    logic              busy_q, done_q, trap_q;
    logic              mar_q, mdr_ld_q, ram_q, rf_q, mux_q, wb_src_q;
    logic              in_wait;
    logic              rd_mfc;
    logic              expired;

    assign in_wait = (state == S_RD_WAIT) || (state == S_WR_WAIT);
    assign rd_mfc  = (state == S_RD_WAIT) && bus.MFC;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .Clk     (Clk),
        .RESET   (RESET),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

    // Next-state and trap-type selection.
    always_comb begin
        state_nxt = state;
        tt_nxt    = TT_NONE;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_illegal(op_q, rd_q)) begin
                    state_nxt = S_TRAP;
                    tt_nxt    = TT_ILLEGAL;
                end else begin
                    state_nxt = S_MAR;
                end
            end
            S_MAR: begin
                if (is_misaligned(op_q, bus.addr_lo, ws_q)) begin
                    state_nxt = S_TRAP;
                    tt_nxt    = TT_ALIGN;
                end else if (is_load(op_q) || is_swap(op_q)) begin
                    state_nxt = S_RD_WAIT;
                end else begin
                    state_nxt = S_MDR_LD;
                end
            end
            S_RD_WAIT: begin
                if (bus.MFC) begin
                    state_nxt = is_swap(op_q) ? S_MDR_LD : S_WB;
                end else if (expired) begin
                    state_nxt = S_TRAP;
                    tt_nxt    = TT_DACC;
                end
            end
            S_MDR_LD: state_nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bus.MFC) begin
                    if (is_swap(op_q))                  state_nxt = S_WB;
                    else if (is_double(op_q) && !ws_q)  state_nxt = S_NEXT;
                    else                                state_nxt = S_FIN;
                end else if (expired) begin
                    state_nxt = S_TRAP;
                    tt_nxt    = TT_DACC;
                end
            end
            S_WB:    state_nxt = (is_double(op_q) && !ws_q) ? S_NEXT : S_FIN;
            S_NEXT:  state_nxt = S_MAR;
            S_FIN:   state_nxt = S_IDLE;
            S_TRAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, latched instruction fields and strobes registered for the upcoming state.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            ws_q     <= 1'b0;
            tt_q     <= TT_NONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
            mar_q    <= 1'b0;
            mdr_ld_q <= 1'b0;
            ram_q    <= 1'b0;
            rf_q     <= 1'b0;
            mux_q    <= 1'b0;
            wb_src_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start) begin
                op_q <= bus.op3;
                rd_q <= bus.rd;
                ws_q <= 1'b0;
                tt_q <= TT_NONE;
            end else if (state_nxt == S_NEXT) begin
                ws_q <= 1'b1;
            end
            if (state_nxt == S_TRAP) tt_q <= tt_nxt;
            busy_q   <= (state_nxt != S_IDLE);
            done_q   <= (state_nxt == S_FIN);
            trap_q   <= (state_nxt == S_TRAP);
            mar_q    <= (state_nxt == S_MAR);
            mdr_ld_q <= (state_nxt == S_MDR_LD);
            ram_q    <= (state_nxt == S_RD_WAIT) || (state_nxt == S_WR_WAIT);
            rf_q     <= (state_nxt == S_WB);
            mux_q    <= (state_nxt == S_RD_WAIT);
            wb_src_q <= (state_nxt == S_WB) && is_swap(op_q);
        end
    end

    // RAM data is only valid while MFC is high, so the read-side capture follows MFC directly.
    assign bus.MDR_Enable     = mdr_ld_q | (rd_mfc & !is_swap(op_q));
    assign bus.TEMP_Enable    = rd_mfc & is_swap(op_q);
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.trap           = trap_q;
    assign bus.tt             = tt_q;
    assign bus.MAR_Enable     = mar_q;
    assign bus.RAM_enable     = ram_q;
    assign bus.register_file  = rf_q;
    assign bus.MDR_Mux_select = mux_q;
    assign bus.wb_src         = wb_src_q;
    assign bus.word_sel       = busy_q & ws_q;
    assign bus.RAM_OpCode     = busy_q ? op_q : '0;
    assign bus.in_PC          = busy_q ? (rd_q | RD_W'(ws_q)) : '0;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomised scoreboard bench for the memory access sequencer.
module tb_mem_access_sequencer;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    localparam logic [5:0] LD   = 6'b000000, LDUB = 6'b000001, LDUH = 6'b000010, LDD  = 6'b000011;
    localparam logic [5:0] ST   = 6'b000100, STB  = 6'b000101, STH  = 6'b000110, STD  = 6'b000111;
    localparam logic [5:0] LDSB = 6'b001001, LDSH = 6'b001010, SWAP = 6'b001111;

    typedef struct packed {
        logic       mar, mdr, ram, temp, rf, mux, wbsrc, ws, done, trap;
        logic [2:0] tt;
        logic [4:0] inpc;
        logic [5:0] opc;
    } ev_t;

    logic Clk   = 1'b0;
    logic RESET = 1'b0;
    always #5 Clk = ~Clk;

    mem_access_sequencer_if bus();

    mem_access_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus)
    );

    ev_t        exp_q[$];
    int         delay_q[$];
    int         lat_q[$];
    int         checks = 0;
    int         fails  = 0;
    int         m_lat;
    int         m_phase;
    logic [2:0] cur_a = 3'b000;
    bit         in_phase = 0;
    int         wcnt, cur_d;
    logic [5:0] ops[11] = '{LD, LDUB, LDUH, LDD, ST, STB, STH, STD, LDSB, LDSH, SWAP};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.busy, bus.done, bus.trap, bus.tt, bus.MAR_Enable, bus.MDR_Enable,
                    bus.RAM_enable, bus.TEMP_Enable, bus.register_file, bus.MDR_Mux_select,
                    bus.wb_src, bus.word_sel, bus.RAM_OpCode, bus.in_PC});
    endfunction

    // ---------------- reference model ----------------
    function automatic int pick_delay(input int mode, input int phase);
        int r;
        case (mode)
            1: return (phase == 0) ? NEVER : 0;
            2: return (phase == 0) ? TIMEOUT - 1 : 0;
            3: return 0;
            4: return NEVER;
            default: begin
                r = int'($urandom % 12);
                if (r == 0) return NEVER;
                if (r == 1) return TIMEOUT - 1;
                return int'($urandom_range(0, 3));
            end
        endcase
    endfunction

    task automatic push_end(input logic is_trap, input logic [2:0] tt);
        ev_t e;
        e = '0;
        e.done = !is_trap;
        e.trap = is_trap;
        e.tt   = is_trap ? tt : 3'd0;
        exp_q.push_back(e);
        m_lat++;
        lat_q.push_back(m_lat);
    endtask

    task automatic wait_ref(input bit rd_side, input bit swap, input bit ws,
                            input logic [5:0] op, input int mode, output bit timed_out);
        ev_t e;
        int  d, n;
        d = pick_delay(mode, m_phase);
        m_phase++;
        delay_q.push_back(d);
        n = (d >= TIMEOUT) ? TIMEOUT : d + 1;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.ram = 1'b1; e.mux = rd_side; e.ws = ws; e.opc = op;
            if (i == d) begin
                e.mdr  = rd_side && !swap;
                e.temp = rd_side && swap;
            end
            exp_q.push_back(e);
            m_lat++;
        end
        timed_out = (d >= TIMEOUT);
    endtask

    task automatic model_txn(input logic [5:0] op, input logic [4:0] rd, input logic [2:0] a, input int mode);
        ev_t        e;
        bit         ld, stq, sw, dbl, word, half, to;
        int         passes;
        logic [2:0] pa;
        ld   = op inside {LD, LDUB, LDUH, LDSB, LDSH, LDD};
        stq  = op inside {ST, STB, STH, STD};
        sw   = (op == SWAP);
        dbl  = op inside {LDD, STD};
        word = op inside {LD, ST, SWAP};
        half = op inside {LDUH, LDSH, STH};
        m_lat = 1;
        m_phase = 0;
        if (!(ld || stq || sw) || (dbl && rd[0])) begin
            push_end(1'b1, 3'd1);
            return;
        end
        passes = dbl ? 2 : 1;
        for (int p = 0; p < passes; p++) begin
            e = '0; e.mar = 1'b1; e.ws = p[0];
            exp_q.push_back(e);
            m_lat++;
            pa = a + 3'(4 * p);
            if ((word && pa[1:0] != 2'b00) || (half && pa[0]) || (dbl && p == 0 && pa != 3'b000)) begin
                push_end(1'b1, 3'd2);
                return;
            end
            if (ld || sw) begin
                wait_ref(1'b1, sw, p[0], op, mode, to);
                if (to) begin push_end(1'b1, 3'd3); return; end
            end
            if (stq || sw) begin
                e = '0; e.mdr = 1'b1; e.ws = p[0];
                exp_q.push_back(e);
                m_lat++;
                wait_ref(1'b0, sw, p[0], op, mode, to);
                if (to) begin push_end(1'b1, 3'd3); return; end
            end
            if (ld || sw) begin
                e = '0; e.rf = 1'b1; e.wbsrc = sw; e.ws = p[0]; e.inpc = rd | 5'(p);
                exp_q.push_back(e);
                m_lat++;
            end
            if (p == 0 && passes == 2) m_lat++;
        end
        push_end(1'b0, 3'd0);
    endtask

    // ---------------- RAM responder: addr_lo in MAR, MFC after the scheduled delay ----------------
    always @(negedge Clk) begin
        if (!RESET) begin
            in_phase    = 0;
            bus.MFC     = 1'b0;
            bus.addr_lo = 3'b000;
        end else begin
            if (bus.MAR_Enable) bus.addr_lo = bus.word_sel ? cur_a + 3'd4 : cur_a;
            if (bus.RAM_enable) begin
                if (!in_phase) begin
                    in_phase = 1;
                    wcnt     = 0;
                    cur_d    = (delay_q.size() > 0) ? delay_q.pop_front() : NEVER;
                end
                bus.MFC = (wcnt == cur_d);
                wcnt++;
            end else begin
                in_phase = 0;
                bus.MFC  = ($urandom % 4 == 0);
            end
        end
    end

    // ---------------- monitor: compare every active output cycle with the scoreboard ----------------
    always @(negedge Clk) begin
        ev_t act, exp;
        #1;
        if (RESET && (bus.MAR_Enable || bus.MDR_Enable || bus.RAM_enable || bus.TEMP_Enable ||
                      bus.register_file || bus.done || bus.trap)) begin
            act       = '0;
            act.mar   = bus.MAR_Enable;
            act.mdr   = bus.MDR_Enable;
            act.ram   = bus.RAM_enable;
            act.temp  = bus.TEMP_Enable;
            act.rf    = bus.register_file;
            act.mux   = bus.MDR_Mux_select;
            act.wbsrc = bus.wb_src;
            act.done  = bus.done;
            act.trap  = bus.trap;
            act.ws    = (act.mar | act.mdr | act.ram | act.temp | act.rf) ? bus.word_sel : 1'b0;
            act.tt    = act.trap ? bus.tt : 3'd0;
            act.inpc  = act.rf ? bus.in_PC : 5'd0;
            act.opc   = act.ram ? bus.RAM_OpCode : 6'd0;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(act), 32'hFFFF_FFFF);
            end else begin
                exp = exp_q.pop_front();
                chk("event", 32'(act), 32'(exp));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 100) begin @(negedge Clk); #2; g++; end
        if (g == 100) chk("idle_wait_expired", 32'd1, 32'd0);
    endtask

    task automatic run_txn(input logic [5:0] op, input logic [4:0] rd, input logic [2:0] a, input int mode);
        int n = 0;
        int exp_lat;
        bit fin = 0;
        wait_idle();
        @(negedge Clk);
        cur_a     = a;
        bus.op3   = op;
        bus.rd    = rd;
        bus.start = 1'b1;
        model_txn(op, rd, a, mode);
        while (!fin && n < 400) begin
            @(negedge Clk); #2;
            n++;
            if (bus.done || bus.trap) fin = 1;
            // Extra start pulses while busy must be ignored.
            bus.start = bus.busy && !fin && ($urandom % 4 == 0);
            if (bus.start) begin
                bus.op3 = 6'($urandom);
                bus.rd  = 5'($urandom);
            end
        end
        exp_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        chk("latency", 32'(fin ? n : -1), 32'(exp_lat));
    endtask

    task automatic reset_mid_write();
        int g = 0;
        wait_idle();
        @(negedge Clk);
        cur_a = 3'b000; bus.op3 = ST; bus.rd = 5'd9; bus.start = 1'b1;
        model_txn(ST, 5'd9, 3'b000, 4);
        @(negedge Clk); #2;
        bus.start = 1'b0;
        while (!bus.RAM_enable && g < 20) begin @(negedge Clk); #2; g++; end
        chk("reached_wr_wait", 32'(bus.RAM_enable), 32'd1);
        @(negedge Clk); #3;
        RESET = 1'b0;
        #1;
        chk("outputs_in_reset", all_outs(), 32'd0);
        exp_q.delete();
        delay_q.delete();
        lat_q.delete();
        repeat (2) @(negedge Clk);
        RESET = 1'b1;
        #2;
        chk("outputs_after_release", all_outs(), 32'd0);
    endtask

    initial begin
        logic [5:0] op;
        logic [4:0] rd;
        logic [2:0] a;
        int         r;
        bus.start = 1'b0;
        bus.op3   = '0;
        bus.rd    = '0;
        #12;
        chk("reset_outputs", all_outs(), 32'd0);
        @(negedge Clk);
        RESET = 1'b1;

        run_txn(LD,   5'd5, 3'b000, 3);
        run_txn(STD,  5'd6, 3'b000, 3);
        run_txn(SWAP, 5'd3, 3'b000, 3);
        run_txn(LDUH, 5'd4, 3'b001, 3);
        repeat (3) @(negedge Clk);
        #2;
        chk("tt_held", 32'(bus.tt), 32'd2);
        run_txn(LDD,  5'd7, 3'b000, 3);
        run_txn(LD,   5'd1, 3'b000, 1);
        run_txn(LD,   5'd2, 3'b000, 2);
        run_txn(LDD,  5'd8, 3'b000, 0);
        run_txn(ST,   5'd1, 3'b010, 0);
        run_txn(STD,  5'd2, 3'b100, 0);
        run_txn(6'b111000, 5'd0, 3'b000, 0);
        reset_mid_write();
        run_txn(LD,   5'd11, 3'b000, 0);

        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom % 12);
            op = (r < 11) ? ops[r] : (6'b010000 | 6'($urandom % 16));
            rd = 5'($urandom);
            if ((op == LDD || op == STD) && ($urandom % 4 != 0)) rd[0] = 1'b0;
            a  = ($urandom % 4 == 0) ? 3'($urandom) : 3'b000;
            run_txn(op, rd, a, 0);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("delays_consumed", 32'(delay_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Clocked sequencer that runs one SPARC load/store/swap instruction through the MAR/MDR/RAM datapath. It replaces the fixed delay chains in the control unit's load/store paths with a state machine that waits on RAM's MFC handshake. The control unit pulses start with the instruction fields and waits for done or trap. The sequencer also handles the two-pass double-word ops (LDD/STD), alignment and illegal-op trap detection, and a memory-response timeout.

Parameters:
TIMEOUT, 15, maximum cycles spent waiting for MFC before a data_access_exception trap.
CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
Clk  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
start  in  1  begin an access; sampled only in IDLE.
op3  in  6  IR_Out[24:19], latched at start.
rd  in  5  IR_Out[29:25], latched at start.
addr_lo  in  3  ALU_out[2:0]; sampled in the MAR state.
MFC  in  1  memory function complete from RAM.
busy  out  1  high from the cycle after start is accepted until done or trap.
done  out  1  one-cycle pulse on successful completion.
trap  out  1  one-cycle pulse on an aborted access.
tt  out  3  trap type; valid with trap and held until the next start.
MAR_Enable, MDR_Enable, RAM_enable, TEMP_Enable, register_file  out  1 each  datapath load strobes.
MDR_Mux_select  out  1  1 = RAM data into MDR; 0 = register data into MDR.
wb_src  out  1  register write-back source: 0 = MDR, 1 = TEMP.
word_sel  out  1  0 = first word; 1 = second word (datapath adds 4 to the address).
RAM_OpCode  out  6  latched op3, driven while busy.
in_PC  out  5  destination register: rd for the first word, rd|1 for the second.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset takes effect immediately, including mid-access. No partial-write recovery is attempted.
- Op decode:
  - Loads: 000000 LD, 000001 LDUB, 000010 LDUH, 001001 LDSB, 001010 LDSH.
  - Stores: 000100 ST, 000101 STB, 000110 STH.
  - Double word: 000011 LDD, 000111 STD.
  - Swap: 001111 SWAP.
  - Any other op3 → tt=3'b001 (illegal_instruction). LDD/STD with odd rd → tt=3'b001.
- Alignment check, done in the MAR state:
  - LD, ST, SWAP require addr_lo[1:0]=00.
  - LDD, STD require addr_lo=000 on the first pass.
  - Half-word ops require addr_lo[0]=0.
  - A violation → tt=3'b010 (mem_address_not_aligned).
- Timeout: no MFC within TIMEOUT cycles of entering a wait state → tt=3'b011 (data_access_exception).
- States:
  - IDLE: on start, latch op3/rd, set word_sel=0 → DECODE. start while busy is ignored.
  - DECODE (1 cycle): illegal → TRAP; otherwise → MAR.
  - MAR (1 cycle): MAR_Enable=1. Misaligned → TRAP. Load-type or swap → RD_WAIT. Store-type → MDR_LD.
  - RD_WAIT: RAM_enable=1, MDR_Mux_select=1, counter increments each cycle.
    - On MFC: MDR_Enable=1 in that cycle (TEMP_Enable=1 instead for swap).
    - Next state: swap → MDR_LD; otherwise → WB.
    - If the counter reaches TIMEOUT-1 without MFC → TRAP. MFC in that same cycle wins over the timeout.
  - MDR_LD (1 cycle): MDR_Mux_select=0, MDR_Enable=1 → WR_WAIT.
  - WR_WAIT: RAM_enable=1. Same MFC/timeout rules as RD_WAIT.
    - On MFC: swap → WB; STD first word → NEXT; otherwise → FIN.
  - WB (1 cycle): register_file=1, wb_src=1 for swap, in_PC=rd|word_sel.
    - LDD first word → NEXT; otherwise → FIN.
  - NEXT (1 cycle): word_sel=1 → MAR.
  - FIN: done=1 for one cycle → IDLE.
  - TRAP: trap=1 for one cycle → IDLE.
- No strobe is asserted in IDLE, FIN or TRAP.
- The counter is cleared on every entry to RD_WAIT or WR_WAIT.
- MFC outside the wait states is ignored.
- Latency for LD with MFC in the first wait cycle: start at cycle 0; DECODE 1, MAR 2, RD_WAIT 3, WB 4, FIN 5 (done high in cycle 5).

Decomposition:
- Shared package:
  - state encoding;
  - tt codes: TT_NONE=0, TT_ILLEGAL=1, TT_ALIGN=2, TT_DACC=3;
  - op3 constants for all eleven memory ops;
  - is_load, is_store, is_double, is_half, is_swap decode functions.
- One sub-module, mem_timeout_counter: clear, enable, expired; parameterized by TIMEOUT and CNT_W.

Test Plan:
- LD, rd=5, addr_lo=000, MFC one cycle into RD_WAIT → MAR_Enable in cycle 2, MDR_Enable in cycle 3, register_file with in_PC=5 in cycle 4, done in cycle 5, trap never asserted.
- STD, rd=6, MFC immediate on both passes → two MAR/MDR_LD/WR_WAIT passes, word_sel=1 on the second pass, done once, register_file never asserted.
- SWAP, rd=3 → ordering TEMP_Enable, MDR_Enable with mux=0, RAM_enable, then register_file with wb_src=1 and in_PC=3.
- LDUH with addr_lo=001 → trap with tt=2 in the cycle after MAR, RAM_enable never asserted. LDD with rd=7 → tt=1 after DECODE.
- LD with MFC never asserted, TIMEOUT=15 → RAM_enable held 15 cycles, then trap with tt=3. Repeat with MFC in the 15th wait cycle → done, no trap.
- RESET low during WR_WAIT → all outputs 0 immediately. After release, a new start begins cleanly from IDLE, and start pulses during busy are ignored.
